bcd_operand_loader: RTL and testbench
=====================================

// Module: bcd_operand_loader
// PURPOSE
//   Digit-serial front end for the 100-digit BCD ripple adder (bcd_fadd chain).
//   Accepts BCD digits one per handshake, LSD first: NDIGITS digits of operand A,
//   then NDIGITS digits of operand B. Presents full-width parallel a/b/cin to the
//   adder and holds them stable until the consumer acknowledges.
//   Also flags any non-BCD input nibble (>9) in the frame.
// PARAMETERS
//   NDIGITS  100  BCD digits per operand; operand width is 4*NDIGITS bits (>=2)
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   clear      in   1          synchronous abort: drop partial frame, go to LOAD_A
//   in_valid   in   1          in_digit/in_cin valid
//   in_ready   out  1          loader can accept a digit
//   in_digit   in   4          BCD digit, LSD of A first
//   in_cin     in   1          carry-in; sampled only with the first A digit
//   op_valid   out  1          op_a/op_b/op_cin complete and stable
//   op_ready   in   1          consumer has taken operands (adder sum captured)
//   op_a       out  4*NDIGITS  operand A, digit k at [4k+3:4k]
//   op_b       out  4*NDIGITS  operand B, same packing
//   op_cin     out  1          carry-in for the adder
//   frame_err  out  1          >=1 digit of this frame was >9 (valid with op_valid)
// BEHAVIOUR
//   Transfer: in_valid && in_ready on a rising edge; one digit per transfer.
//   FSM states: LOAD_A, LOAD_B, HOLD. Reset state LOAD_A.
//   Reset (rst_n=0, async): state=LOAD_A, digit count=0, op_a=op_b=0,
//     op_cin=0, frame_err=0, op_valid=0, in_ready=1 (after reset release).
//   in_ready = 1 in LOAD_A/LOAD_B, 0 in HOLD. op_valid = 1 only in HOLD.
//   LOAD_A: on transfer, op_a <= {d, op_a[4N-1:4]} (shift right, new digit enters
//     top), so after N transfers the first digit sits at [3:0]. Count 0..N-1.
//     Count 0: op_cin <= in_cin; frame_err <= (in_digit>9).
//     Transfer at count N-1: count <= 0, state <= LOAD_B.
//   LOAD_B: same shift into op_b; transfer at count N-1 -> HOLD.
//   Stored digit d = in_digit if <=9; if >9, d = 4'h0 and frame_err set (sticky
//     for the rest of the frame). Any digit >9 (10..15) is an error.
//   Latency: op_valid rises on the cycle after the 2N-th accepted digit.
//   HOLD: op_a/op_b/op_cin/frame_err held constant. op_ready=1 -> state LOAD_A
//     next cycle, op_valid drops; registers keep values until overwritten.
//     op_ready while op_valid=0 is ignored.
//   in_valid while in_ready=0 (HOLD): digit not consumed; source must hold it.
//   Back-to-back: digit offered in the cycle after the op_ready handshake is
//     accepted as A digit 0 of the next frame (no dead cycles beyond that).
//   clear: highest priority after reset; state<=LOAD_A, count<=0, op_valid<=0,
//     frame_err<=0; digit presented in the same cycle is discarded. Operand
//     registers are not zeroed.
//   Async reset mid-frame or in HOLD: immediate return to reset values; the
//     partial frame is lost.
//   Counter width $clog2(NDIGITS); count never exceeds N-1.
// TESTING
//   N=100: A=1 digit 9 followed by 99 zeros, B digits all 0, cin=1 -> op_valid after
//     200th digit, op_a[3:0]=9, op_cin=1, frame_err=0; adder sum[3:0]=0,sum[7:4]=1.
//   N=100: A, B all digits 9, cin=1, in_valid held 1 -> op_valid on cycle 201,
//     op_a=op_b=all 9s; adder sum all 9s, cout=1.
//   N=4: digit 4'hB as A digit 2 -> stored 0, frame_err=1 at op_valid; next frame
//     with clean digits -> frame_err=0.
//   N=4: hold op_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0,
//     op_a/op_b stable; op_ready=1 -> next cycle in_ready=1, digit taken as A[0].
//   N=4: clear after 3 A digits, then a full frame -> op_a equals only new digits.
//   N=4: rst_n low during LOAD_B -> all outputs at reset values asynchronously,
//     next frame loads correctly from A digit 0.

Source files
------------

// File: rtl/bcd_operand_loader.sv
// Digit-serial loader for the BCD ripple adder: shifts in NDIGITS digits of A then B (LSD first),
// holds the parallel operands with op_valid until op_ready; flags any non-BCD nibble in the frame.
module bcd_operand_loader #(
  parameter int NDIGITS = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_digit,
  input  logic                   in_cin,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [4*NDIGITS-1:0]   op_a,
  output logic [4*NDIGITS-1:0]   op_b,
  output logic                   op_cin,
  output logic                   frame_err
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            op_cin_q, op_cin_d;
  logic            frame_err_q, frame_err_d;

  logic            xfer;
  logic            bad;
  logic            last;
  logic [3:0]      dig;

  assign in_ready  = (state_q != HOLD);
  assign op_valid  = (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_cin    = op_cin_q;
  assign frame_err = frame_err_q;

  assign xfer = in_valid && in_ready;
  assign bad  = (in_digit > 4'd9);
  assign dig  = bad ? 4'h0 : in_digit;
  assign last = (cnt_q == CW'(NDIGITS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    frame_err_d = frame_err_q;

    if (clear) begin
      // Operand registers intentionally keep their contents on abort.
      state_d     = LOAD_A;
      cnt_d       = '0;
      frame_err_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (xfer) begin
            op_a_d = {dig, op_a_q[W-1:4]};
            if (cnt_q == '0) begin
              op_cin_d    = in_cin;
              frame_err_d = bad;
            end else begin
              frame_err_d = frame_err_q | bad;
            end
            if (last) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            op_b_d      = {dig, op_b_q[W-1:4]};
            frame_err_d = frame_err_q | bad;
            if (last) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (op_ready) state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader: one N=4 instance and one N=100 instance on a shared clock.
module tb_bcd_operand_loader;

  logic clk;
  logic rst_n;
  logic clear;

  logic        iv4, ir4, cin4, ov4, ordy4, oc4, fe4;
  logic [3:0]  dig4;
  logic [15:0] a4, b4;

  logic         iv1, ir1, cin1, ov1, ordy1, oc1, fe1;
  logic [3:0]   dig1;
  logic [399:0] a1, b1;

  int errors = 0;
  int checks = 0;

  bcd_operand_loader #(.NDIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv4), .in_ready(ir4), .in_digit(dig4), .in_cin(cin4),
    .op_valid(ov4), .op_ready(ordy4), .op_a(a4), .op_b(b4),
    .op_cin(oc4), .frame_err(fe4)
  );

  bcd_operand_loader #(.NDIGITS(100)) u_dut100 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(iv1), .in_ready(ir1), .in_digit(dig1), .in_cin(cin1),
    .op_valid(ov1), .op_ready(ordy1), .op_a(a1), .op_b(b1),
    .op_cin(oc1), .frame_err(fe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transfer on the N=4 instance; returns #1 after the accepting edge.
  task automatic push4(input logic [3:0] d, input logic c);
    @(negedge clk);
    iv4 = 1'b1; dig4 = d; cin4 = c;
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic push1(input logic [3:0] d, input logic c);
    @(negedge clk);
    iv1 = 1'b1; dig1 = d; cin1 = c;
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic ack4();
    @(negedge clk);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic ack1();
    @(negedge clk);
    ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    iv4 = 0; dig4 = 0; cin4 = 0; ordy4 = 0;
    iv1 = 0; dig1 = 0; cin1 = 0; ordy1 = 0;
    #23;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b exp 0", ov4); end
    checks++; if ({a4, b4} !== 32'h0) begin errors++; $display("FAIL reset_ops got %h exp 0", {a4, b4}); end
    checks++; if ({oc4, fe4} !== 2'b00) begin errors++; $display("FAIL reset_cin_err got %b exp 00", {oc4, fe4}); end
    checks++; if ({ov1, oc1, fe1, ir1} !== 4'b0001) begin errors++; $display("FAIL reset_n100 got %b exp 0001", {ov1, oc1, fe1, ir1}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_frame_err();
    push4(4'h1, 1'b0); push4(4'h2, 1'b0); push4(4'hB, 1'b0); push4(4'h3, 1'b0);
    push4(4'h4, 1'b0); push4(4'h5, 1'b0); push4(4'h6, 1'b0);
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL err_early_valid got %b exp 0", ov4); end
    push4(4'h7, 1'b0);
    checks++; if ({ov4, ir4} !== 2'b10) begin errors++; $display("FAIL err_hold_flags got %b exp 10", {ov4, ir4}); end
    checks++; if (a4 !== 16'h3021) begin errors++; $display("FAIL err_op_a got %h exp 3021", a4); end
    checks++; if (b4 !== 16'h7654) begin errors++; $display("FAIL err_op_b got %h exp 7654", b4); end
    checks++; if ({fe4, oc4} !== 2'b10) begin errors++; $display("FAIL err_flag got %b exp 10", {fe4, oc4}); end
    ack4();
    checks++; if ({ov4, ir4} !== 2'b01) begin errors++; $display("FAIL err_release got %b exp 01", {ov4, ir4}); end
    push4(4'h9, 1'b1); push4(4'h8, 1'b0); push4(4'h7, 1'b0); push4(4'h6, 1'b0);
    push4(4'h0, 1'b0); push4(4'h1, 1'b0); push4(4'h2, 1'b0); push4(4'h3, 1'b0);
    checks++; if ({a4, b4} !== 32'h6789_3210) begin errors++; $display("FAIL clean_ops got %h exp 67893210", {a4, b4}); end
    checks++; if ({ov4, fe4, oc4} !== 3'b101) begin errors++; $display("FAIL clean_flags got %b exp 101", {ov4, fe4, oc4}); end
  endtask

  task automatic test_back_to_back();
    // Still in HOLD from the previous frame with 16'h6789 / 16'h3210.
    @(negedge clk);
    iv4 = 1'b1; dig4 = 4'h5; cin4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ir4, ov4, a4, b4} !== {2'b01, 32'h6789_3210}) begin
        errors++; $display("FAIL hold_stall cyc %0d got %b %b %h exp 0 1 67893210", i, ir4, ov4, {a4, b4});
      end
    end
    @(negedge clk); ordy4 = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ir4, ov4} !== 2'b10) begin errors++; $display("FAIL b2b_release got %b exp 10", {ir4, ov4}); end
    @(negedge clk); ordy4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    push4(4'h1, 1'b0); push4(4'h2, 1'b0); push4(4'h3, 1'b0);
    push4(4'h4, 1'b0); push4(4'h4, 1'b0); push4(4'h4, 1'b0); push4(4'h4, 1'b0);
    checks++; if ({ov4, a4, b4, oc4} !== {1'b1, 32'h3215_4444, 1'b0}) begin
      errors++; $display("FAIL b2b_frame got %b %h %b exp 1 32154444 0", ov4, {a4, b4}, oc4);
    end
    ack4();
  endtask

  task automatic test_clear();
    push4(4'h7, 1'b1); push4(4'hF, 1'b0); push4(4'h7, 1'b0);
    checks++; if (fe4 !== 1'b1) begin errors++; $display("FAIL clr_pre_err got %b exp 1", fe4); end
    @(negedge clk);
    clear = 1'b1; iv4 = 1'b1; dig4 = 4'h9;
    @(posedge clk); #1;
    clear = 1'b0; iv4 = 1'b0;
    checks++; if ({fe4, ir4, ov4} !== 3'b010) begin errors++; $display("FAIL clr_state got %b exp 010", {fe4, ir4, ov4}); end
    push4(4'h1, 1'b0); push4(4'h2, 1'b0); push4(4'h3, 1'b0); push4(4'h4, 1'b0);
    push4(4'h5, 1'b0); push4(4'h6, 1'b0); push4(4'h7, 1'b0); push4(4'h8, 1'b0);
    checks++; if ({ov4, a4, b4, oc4, fe4} !== {1'b1, 32'h4321_8765, 2'b00}) begin
      errors++; $display("FAIL clr_frame got %b %h %b%b exp 1 43218765 00", ov4, {a4, b4}, oc4, fe4);
    end
    ack4();
  endtask

  task automatic test_async_reset();
    push4(4'h9, 1'b1); push4(4'h9, 1'b0); push4(4'hC, 1'b0); push4(4'h9, 1'b0);
    push4(4'h9, 1'b0); push4(4'h9, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ir4, ov4, oc4, fe4, a4, b4} !== {4'b1000, 32'h0}) begin
      errors++; $display("FAIL arst_vals got %b%b%b%b %h exp 1000 0", ir4, ov4, oc4, fe4, {a4, b4});
    end
    @(negedge clk); rst_n = 1'b1;
    push4(4'h2, 1'b1); push4(4'h4, 1'b0); push4(4'h6, 1'b0); push4(4'h8, 1'b0);
    push4(4'h1, 1'b0); push4(4'h3, 1'b0); push4(4'h5, 1'b0); push4(4'h7, 1'b0);
    checks++; if ({ov4, a4, b4, oc4, fe4} !== {1'b1, 32'h8642_7531, 2'b10}) begin
      errors++; $display("FAIL arst_frame got %b %h %b%b exp 1 86427531 10", ov4, {a4, b4}, oc4, fe4);
    end
    ack4();
  endtask

  task automatic test_n100_single();
    logic [399:0] exp_a;
    exp_a = '0;
    exp_a[3:0] = 4'h9;
    push1(4'h9, 1'b1);
    for (int i = 1; i < 199; i++) push1(4'h0, 1'b0);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL n100_early_valid got %b exp 0", ov1); end
    push1(4'h0, 1'b0);
    checks++; if ({ov1, oc1, fe1} !== 3'b110) begin errors++; $display("FAIL n100_flags got %b exp 110", {ov1, oc1, fe1}); end
    checks++; if (a1 !== exp_a) begin errors++; $display("FAIL n100_op_a got %h exp %h", a1, exp_a); end
    checks++; if (b1 !== 400'h0) begin errors++; $display("FAIL n100_op_b got %h exp 0", b1); end
    ack1();
  endtask

  task automatic test_n100_all9();
    logic [399:0] exp_9;
    int n;
    for (int k = 0; k < 100; k++) exp_9[4*k +: 4] = 4'h9;
    n = 0;
    @(negedge clk);
    iv1 = 1'b1; dig1 = 4'h9; cin1 = 1'b1;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      cin1 = 1'b0;
      if (ov1) break;
    end
    checks++; if (n !== 200) begin errors++; $display("FAIL n100_latency got %0d edges exp 200", n); end
    checks++; if ({ir1, oc1, fe1} !== 3'b010) begin errors++; $display("FAIL n100_9_flags got %b exp 010", {ir1, oc1, fe1}); end
    checks++; if ({a1, b1} !== {exp_9, exp_9}) begin errors++; $display("FAIL n100_all9 got %h exp all 9", a1); end
    iv1 = 1'b0;
    ack1();
    checks++; if ({ov1, ir1} !== 2'b01) begin errors++; $display("FAIL n100_release got %b exp 01", {ov1, ir1}); end
  endtask

  initial begin
    test_reset();
    test_frame_err();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_n100_single();
    test_n100_all9();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
